// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the cascaded skid-register pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipeline_pkg;

  // Legal range for the number of cascaded stages.
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 16;

  // Bits needed to count 0..2*depth held words.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipeline_skid_stage.sv
// One pipeline stage: main register plus a skid register for a stalled downstream.
// Latency: 1 cycle from input transfer to out_vld when the stage is empty.
// Backpressure: in_rdy is a flop (skid slot empty), never combinational from out_rdy.
module pipeline_skid_stage
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy
);

  logic             main_vld;
  logic [WIDTH-1:0] main_dat;
  logic             skid_vld;
  logic [WIDTH-1:0] skid_dat;
  logic             rdy_q;
  logic             in_xfer;

  assign in_rdy  = rdy_q;
  assign out_vld = main_vld;
  assign out_dat = main_dat;
  assign in_xfer = in_vld && rdy_q;

  // Main/skid occupancy; ready tracks "skid empty" and stays low through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld <= 1'b0;
      main_dat <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
      rdy_q    <= 1'b0;
    end else if (flush) begin
      // Drops everything, including a word entering on this edge.
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else if (!main_vld || out_rdy) begin
      // Main slot frees up: refill from skid first (input is blocked then), else from input.
      if (skid_vld) begin
        main_vld <= 1'b1;
        main_dat <= skid_dat;
        skid_vld <= 1'b0;
      end else begin
        main_vld <= in_xfer;
        if (in_xfer) begin
          main_dat <= in_dat;
        end
      end
      rdy_q <= 1'b1;
    end else if (in_xfer) begin
      // Downstream stalled with main full: park the incoming word in the skid slot.
      skid_vld <= 1'b1;
      skid_dat <= in_dat;
      rdy_q    <= 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_chain.sv
// DEPTH cascaded skid stages; PIPELINE_OCCUPANCY_EN adds an 'occupancy' held-word count.
// Latency: DEPTH cycles from input transfer to out_valid through an empty chain.
// Backpressure: prev_ready is stage 0's registered ready; capacity is 2*DEPTH words.
module pipeline_chain
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] data_in,
  input  logic             previous,
  output logic             prev_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             next,
  input  logic             flush
`ifdef PIPELINE_OCCUPANCY_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_check
    $error("pipeline_chain: DEPTH outside supported range");
  end

  // Link i feeds stage i; link DEPTH is the chain output.
  logic             vld [DEPTH+1];
  logic             rdy [DEPTH+1];
  logic [WIDTH-1:0] dat [DEPTH+1];

  assign vld[0]     = previous;
  assign dat[0]     = data_in;
  assign rdy[DEPTH] = next;
  assign prev_ready = rdy[0];
  assign out_valid  = vld[DEPTH];
  assign data_out   = dat[DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipeline_skid_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (RST),
      .flush   (flush),
      .in_vld  (vld[i]),
      .in_dat  (dat[i]),
      .in_rdy  (rdy[i]),
      .out_vld (vld[i+1]),
      .out_dat (dat[i+1]),
      .out_rdy (rdy[i+1])
    );
  end

`ifdef PIPELINE_OCCUPANCY_EN
  localparam int OW = occ_width(DEPTH);

  logic [OW-1:0] occ_q;
  logic          in_xfer;
  logic          out_xfer;

  assign in_xfer   = previous && prev_ready;
  assign out_xfer  = out_valid && next;
  assign occupancy = occ_q;

  // Held-word count; cannot exceed 2*DEPTH because ready drops when every slot is full.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OW'(in_xfer) - OW'(out_xfer);
    end
  end
`endif

endmodule
